// File: rtl/mips_control_unit_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// Carries the decoded instruction fields and ALU flags into the controller, and
// every register load, reset, write strobe and mux select back out to the datapath.
//   master : controller side (drives strobes/selects, reads Opcode/Funct/Zero/Overflow)
//   slave  : datapath side (the mirror image)
interface mips_control_unit_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       Overflow;

  logic       PC_reset;
  logic       MDR_reset;
  logic       Instr_Reg_reset;
  logic       PC_load;
  logic       MDR_load;
  logic       IRWrite;
  logic       A_load;
  logic       B_load;
  logic       AluOut_load;
  logic       EPC_load;
  logic       wr;
  logic       RegWrite;
  logic       IorD;
  logic       RegDst;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALU_sel;
  logic [1:0] PCSource;
  logic [7:0] Estado;

  modport master (
    input  Opcode, Funct, Zero, Overflow,
    output PC_reset, MDR_reset, Instr_Reg_reset, PC_load, MDR_load, IRWrite, A_load,
           B_load, AluOut_load, EPC_load, wr, RegWrite, IorD, RegDst, MemtoReg, ALUSrcA,
           ALUSrcB, ALU_sel, PCSource, Estado
  );

  modport slave (
    output Opcode, Funct, Zero, Overflow,
    input  PC_reset, MDR_reset, Instr_Reg_reset, PC_load, MDR_load, IRWrite, A_load,
           B_load, AluOut_load, EPC_load, wr, RegWrite, IorD, RegDst, MemtoReg, ALUSrcA,
           ALUSrcB, ALU_sel, PCSource, Estado
  );
endinterface

// File: rtl/mips_control_unit.sv
// Multicycle MIPS controller: fetch, decode, R-type, addi, lw, sw, beq, bne, j.
// Ports:
//   Clk      - rising-edge clock
//   Reset_n  - asynchronous active-low reset (forces RESET state and datapath clears)
//   bus_io   - mips_control_unit_if.master: instruction fields/flags in, strobes/selects out
// Configuration macro: MIPS_EXCEPTION_EN enables overflow and invalid-opcode exceptions
// (EXC_OVF/EXC_OPC, EPC <- PC - 4, PC <- 32'h0000_00FC). Without it overflow is ignored
// and unknown instructions retire as NOPs.
// Outputs are registered from the next state; the only combinational output path is
// the branch PC_load, which follows Zero during BRANCH.
module mips_control_unit (
  input logic                 Clk,
  input logic                 Reset_n,
  mips_control_unit_if.master bus_io
);

  typedef enum logic [4:0] {
    StReset = 5'd0, StFetch = 5'd1, StFetchWait = 5'd2, StDecode = 5'd3, StMemAddr = 5'd4,
    StLwRead = 5'd5, StLwWait = 5'd6, StLwWb = 5'd7, StSwWrite = 5'd8, StRExec = 5'd9,
    StRWb = 5'd10, StBranch = 5'd11, StJump = 5'd12, StAddiExec = 5'd13, StAddiWb = 5'd14,
    StExcOvf = 5'd15, StExcOpc = 5'd16
  } state_e;

  typedef struct packed {
    logic       pc_reset, mdr_reset, ir_reset;
    logic       pc_load, mdr_load, ir_write, a_load, b_load, aluout_load, epc_load;
    logic       wr, reg_write, iord, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_sel;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [2:0] AluAdd = 3'b001;
  localparam logic [2:0] AluSub = 3'b010;

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  function automatic logic r_funct_ok(logic [5:0] f);
    return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) || (f == 6'h26) || (f == 6'h2A);
  endfunction

  function automatic logic [2:0] r_alu_sel(logic [5:0] f);
    logic [2:0] sel;
    case (f)
      6'h22:   sel = AluSub;
      6'h24:   sel = 3'b011;
      6'h26:   sel = 3'b110;
      6'h2A:   sel = 3'b111;
      default: sel = AluAdd;
    endcase
    return sel;
  endfunction

  // Control word for the cycle spent in state st.
  function automatic ctrl_t decode_ctrl(state_e st, logic [5:0] f);
    ctrl_t c;
    c = '0;
    case (st)
      StReset: begin
        c.pc_reset = 1'b1;
        c.mdr_reset = 1'b1;
        c.ir_reset = 1'b1;
      end
      StFetchWait: begin
        c.ir_write = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_sel = AluAdd;
        c.pc_load = 1'b1;
      end
      StDecode: begin
        c.a_load = 1'b1;
        c.b_load = 1'b1;
        c.alu_src_b = 2'b11;
        c.alu_sel = AluAdd;
        c.aluout_load = 1'b1;
      end
      StRExec: begin
        c.alu_src_a = 1'b1;
        c.alu_sel = r_alu_sel(f);
        c.aluout_load = 1'b1;
      end
      StRWb: begin
        c.reg_dst = 1'b1;
        c.reg_write = 1'b1;
      end
      StAddiExec, StMemAddr: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_sel = AluAdd;
        c.aluout_load = 1'b1;
      end
      StAddiWb:  c.reg_write = 1'b1;
      StLwRead:  c.iord = 1'b1;
      StLwWait:  c.mdr_load = 1'b1;
      StLwWb: begin
        c.mem_to_reg = 1'b1;
        c.reg_write = 1'b1;
      end
      StSwWrite: begin
        c.iord = 1'b1;
        c.wr = 1'b1;
      end
      // PC_load here is added combinationally from Zero.
      StBranch: begin
        c.alu_src_a = 1'b1;
        c.alu_sel = AluSub;
        c.pc_source = 2'b01;
      end
      StJump: begin
        c.pc_source = 2'b10;
        c.pc_load = 1'b1;
      end
`ifdef MIPS_EXCEPTION_EN
      StExcOvf, StExcOpc: begin
        c.alu_src_b = 2'b01;
        c.alu_sel = AluSub;
        c.epc_load = 1'b1;
        c.pc_source = 2'b11;
        c.pc_load = 1'b1;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      StReset:     state_d = StFetch;
      StFetch:     state_d = StFetchWait;
      StFetchWait: state_d = StDecode;
      StDecode: begin
        if (bus_io.Opcode == OpRType && r_funct_ok(bus_io.Funct)) state_d = StRExec;
        else if (bus_io.Opcode == OpLw || bus_io.Opcode == OpSw) state_d = StMemAddr;
        else if (bus_io.Opcode == OpBeq || bus_io.Opcode == OpBne) state_d = StBranch;
        else if (bus_io.Opcode == OpJ) state_d = StJump;
        else if (bus_io.Opcode == OpAddi) state_d = StAddiExec;
`ifdef MIPS_EXCEPTION_EN
        else state_d = StExcOpc;
`else
        else state_d = StFetch;
`endif
      end
      StMemAddr:   state_d = (bus_io.Opcode == OpLw) ? StLwRead : StSwWrite;
      StLwRead:    state_d = StLwWait;
      StLwWait:    state_d = StLwWb;
`ifdef MIPS_EXCEPTION_EN
      // Only add/sub trap; and/xor/slt never overflow architecturally.
      StRExec:     state_d = (bus_io.Overflow && (bus_io.Funct == 6'h20 || bus_io.Funct == 6'h22))
                             ? StExcOvf : StRWb;
      StAddiExec:  state_d = bus_io.Overflow ? StExcOvf : StAddiWb;
`else
      StRExec:     state_d = StRWb;
      StAddiExec:  state_d = StAddiWb;
`endif
      default:     state_d = StFetch;
    endcase
  end

  always_comb ctrl_d = decode_ctrl(state_d, bus_io.Funct);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StReset;
      ctrl_q  <= decode_ctrl(StReset, 6'h00);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

`ifndef MIPS_EXCEPTION_EN
  logic unused_overflow;
  assign unused_overflow = bus_io.Overflow;
`endif

  // Opcode[0] distinguishes bne (0x05) from beq (0x04).
  logic branch_taken;
  assign branch_taken = (state_q == StBranch) && (bus_io.Opcode[0] ? !bus_io.Zero : bus_io.Zero);

  assign bus_io.PC_reset        = ctrl_q.pc_reset;
  assign bus_io.MDR_reset       = ctrl_q.mdr_reset;
  assign bus_io.Instr_Reg_reset = ctrl_q.ir_reset;
  assign bus_io.PC_load         = ctrl_q.pc_load | branch_taken;
  assign bus_io.MDR_load        = ctrl_q.mdr_load;
  assign bus_io.IRWrite         = ctrl_q.ir_write;
  assign bus_io.A_load          = ctrl_q.a_load;
  assign bus_io.B_load          = ctrl_q.b_load;
  assign bus_io.AluOut_load     = ctrl_q.aluout_load;
  assign bus_io.EPC_load        = ctrl_q.epc_load;
  assign bus_io.wr              = ctrl_q.wr;
  assign bus_io.RegWrite        = ctrl_q.reg_write;
  assign bus_io.IorD            = ctrl_q.iord;
  assign bus_io.RegDst          = ctrl_q.reg_dst;
  assign bus_io.MemtoReg        = ctrl_q.mem_to_reg;
  assign bus_io.ALUSrcA         = ctrl_q.alu_src_a;
  assign bus_io.ALUSrcB         = ctrl_q.alu_src_b;
  assign bus_io.ALU_sel         = ctrl_q.alu_sel;
  assign bus_io.PCSource        = ctrl_q.pc_source;
  assign bus_io.Estado          = {3'b000, state_q};

endmodule

// File: tb/tb_mips_control_unit.sv
// Directed bench for mips_control_unit: expected values are queued per cycle and
// compared against the DUT outputs sampled 1 time unit after each rising edge.
module tb_mips_control_unit;

  logic Clk;
  logic Reset_n;
  mips_control_unit_if bus ();

  mips_control_unit dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus_io  (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  localparam int FEstado = 0;
  localparam int FResets = 1;   // {PC_reset, MDR_reset, Instr_Reg_reset}
  localparam int FWrites = 2;   // OR of every load/write strobe
  localparam int FPcLoad = 3;
  localparam int FIrWrite = 4;
  localparam int FRegWrite = 5;
  localparam int FRegDst = 6;
  localparam int FMemtoReg = 7;
  localparam int FIorD = 8;
  localparam int FWr = 9;
  localparam int FMdrLoad = 10;
  localparam int FEpcLoad = 11;
  localparam int FPcSource = 12;
  localparam int FAluSel = 13;
  localparam int FAluOutLoad = 14;

  typedef struct {
    string      tag;
    int         field;
    logic [7:0] value;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] get_obs(int f);
    logic [7:0] v;
    case (f)
      FEstado:     v = bus.Estado;
      FResets:     v = {5'b0, bus.PC_reset, bus.MDR_reset, bus.Instr_Reg_reset};
      FWrites:     v = {7'b0, bus.PC_load | bus.MDR_load | bus.IRWrite | bus.A_load | bus.B_load
                              | bus.AluOut_load | bus.EPC_load | bus.wr | bus.RegWrite};
      FPcLoad:     v = {7'b0, bus.PC_load};
      FIrWrite:    v = {7'b0, bus.IRWrite};
      FRegWrite:   v = {7'b0, bus.RegWrite};
      FRegDst:     v = {7'b0, bus.RegDst};
      FMemtoReg:   v = {7'b0, bus.MemtoReg};
      FIorD:       v = {7'b0, bus.IorD};
      FWr:         v = {7'b0, bus.wr};
      FMdrLoad:    v = {7'b0, bus.MDR_load};
      FEpcLoad:    v = {7'b0, bus.EPC_load};
      FPcSource:   v = {6'b0, bus.PCSource};
      FAluSel:     v = {5'b0, bus.ALU_sel};
      FAluOutLoad: v = {7'b0, bus.AluOut_load};
      default:     v = 8'hxx;
    endcase
    return v;
  endfunction

  task automatic expect_val(input string tag, input int field, input logic [7:0] value);
    sb.push_back('{tag, field, value});
  endtask

  task automatic drain();
    exp_t       it;
    logic [7:0] obs;
    while (sb.size() > 0) begin
      it  = sb.pop_front();
      obs = get_obs(it.field);
      checks++;
      assert (obs === it.value)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", it.tag, obs, it.value);
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic step_state(input string tag, input logic [7:0] st);
    tick();
    expect_val(tag, FEstado, st);
    drain();
  endtask

  // Fetch + fetch-wait + decode with the given instruction fields.
  task automatic front_end(input string tag, input logic [5:0] op, input logic [5:0] fn);
    bus.Opcode = op;
    bus.Funct  = fn;
    step_state({tag, "_fetch"}, 8'd1);
    step_state({tag, "_fwait"}, 8'd2);
    expect_val({tag, "_fwait_ir"}, FIrWrite, 8'd1);
    expect_val({tag, "_fwait_pc"}, FPcLoad, 8'd1);
    drain();
    step_state({tag, "_decode"}, 8'd3);
  endtask

  initial begin
    Reset_n      = 1'b0;
    bus.Opcode   = 6'h00;
    bus.Funct    = 6'h20;
    bus.Zero     = 1'b0;
    bus.Overflow = 1'b0;

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_val("rst_estado", FEstado, 8'd0);
      expect_val("rst_resets", FResets, 8'd7);
      expect_val("rst_writes", FWrites, 8'd0);
      drain();
    end
    Reset_n = 1'b1;
    #1;
    expect_val("rel_estado", FEstado, 8'd0);
    drain();

    // add $3,$1,$2
    front_end("add", 6'h00, 6'h20);
    step_state("add_exec", 8'd9);
    expect_val("add_alusel", FAluSel, 8'd1);
    expect_val("add_aluout", FAluOutLoad, 8'd1);
    drain();
    step_state("add_wb", 8'd10);
    expect_val("add_regwrite", FRegWrite, 8'd1);
    expect_val("add_regdst", FRegDst, 8'd1);
    drain();

    // lw $4,8($1)
    front_end("lw", 6'h23, 6'h08);
    step_state("lw_addr", 8'd4);
    step_state("lw_read", 8'd5);
    expect_val("lw_iord", FIorD, 8'd1);
    drain();
    step_state("lw_wait", 8'd6);
    expect_val("lw_mdrload", FMdrLoad, 8'd1);
    drain();
    step_state("lw_wb", 8'd7);
    expect_val("lw_memtoreg", FMemtoReg, 8'd1);
    expect_val("lw_regwrite", FRegWrite, 8'd1);
    expect_val("lw_regdst", FRegDst, 8'd0);
    drain();

    // beq: PC_load follows Zero combinationally.
    bus.Zero = 1'b1;
    front_end("beq", 6'h04, 6'h00);
    step_state("beq_state", 8'd11);
    expect_val("beq_taken", FPcLoad, 8'd1);
    expect_val("beq_pcsrc", FPcSource, 8'd1);
    expect_val("beq_alusel", FAluSel, 8'd2);
    drain();
    bus.Zero = 1'b0;
    #1;
    expect_val("beq_not_taken", FPcLoad, 8'd0);
    drain();

    // bne: inverse sense.
    front_end("bne", 6'h05, 6'h00);
    step_state("bne_state", 8'd11);
    expect_val("bne_taken", FPcLoad, 8'd1);
    drain();
    bus.Zero = 1'b1;
    #1;
    expect_val("bne_not_taken", FPcLoad, 8'd0);
    drain();
    bus.Zero = 1'b0;

    // j
    front_end("j", 6'h02, 6'h00);
    step_state("j_state", 8'd12);
    expect_val("j_pcload", FPcLoad, 8'd1);
    expect_val("j_pcsrc", FPcSource, 8'd2);
    drain();

    // sw
    front_end("sw", 6'h2B, 6'h00);
    step_state("sw_addr", 8'd4);
    step_state("sw_write", 8'd8);
    expect_val("sw_wr", FWr, 8'd1);
    expect_val("sw_iord", FIorD, 8'd1);
    drain();

    // addi without overflow
    front_end("addi", 6'h08, 6'h00);
    step_state("addi_exec", 8'd13);
    step_state("addi_wb", 8'd14);
    expect_val("addi_regwrite", FRegWrite, 8'd1);
    expect_val("addi_regdst", FRegDst, 8'd0);
    drain();

`ifdef MIPS_EXCEPTION_EN
    front_end("addiovf", 6'h08, 6'h00);
    step_state("addiovf_exec", 8'd13);
    bus.Overflow = 1'b1;
    step_state("addiovf_exc", 8'd15);
    expect_val("addiovf_epc", FEpcLoad, 8'd1);
    expect_val("addiovf_pcsrc", FPcSource, 8'd3);
    expect_val("addiovf_regwrite", FRegWrite, 8'd0);
    drain();
    bus.Overflow = 1'b0;

    front_end("badop", 6'h3F, 6'h00);
    step_state("badop_exc", 8'd16);
    expect_val("badop_epc", FEpcLoad, 8'd1);
    drain();
`else
    front_end("badop", 6'h3F, 6'h00);
    step_state("badop_nop", 8'd1);
    // Re-enter fetch state sequence from the NOP's return to FETCH.
    step_state("badop_fwait", 8'd2);
    step_state("badop_decode2", 8'd3);
    bus.Opcode = 6'h00;
    bus.Funct  = 6'h20;
    step_state("addovf_exec", 8'd9);
    bus.Overflow = 1'b1;
    step_state("addovf_wb", 8'd10);
    expect_val("addovf_regwrite", FRegWrite, 8'd1);
    expect_val("addovf_epc", FEpcLoad, 8'd0);
    drain();
    bus.Overflow = 1'b0;
`endif

    // Reset in the middle of an R-type write-back.
    front_end("midrst", 6'h00, 6'h22);
    step_state("midrst_exec", 8'd9);
    expect_val("midrst_sub", FAluSel, 8'd2);
    drain();
    step_state("midrst_wb", 8'd10);
    expect_val("midrst_wb_rw", FRegWrite, 8'd1);
    drain();
    Reset_n = 1'b0;
    #1;
    expect_val("midrst_estado", FEstado, 8'd0);
    expect_val("midrst_writes", FWrites, 8'd0);
    expect_val("midrst_resets", FResets, 8'd7);
    drain();
    tick();
    Reset_n = 1'b1;
    step_state("midrst_fetch", 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_control_unit.md
# mips_control_unit

Multicycle Moore/Mealy controller that sequences the MIPS datapath: program counter, memory, instruction register, MDR, register bank, A/B, ALU and ALUOut. It decodes opcode/funct from the instruction register and drives every load, select and write strobe one state per cycle. It implements fetch, decode, R-type, addi, lw, sw, beq, bne and j, plus optional overflow and invalid-opcode exceptions through EPC.

## Interface
- No parameters. The exception vector is fixed at 32'h0000_00FC.
- `Clk` in 1: single clock, rising edge.
- `Reset_n` in 1: asynchronous, active-low.
- `Opcode` in 6: Instr31_26.
- `Funct` in 6: Instr15_0[5:0].
- `Zero` in 1: ALU zero flag.
- `Overflow` in 1: ALU overflow flag.
- `PC_reset`, `MDR_reset`, `Instr_Reg_reset` out 1: datapath register clears.
- `PC_load`, `MDR_load`, `IRWrite`, `A_load`, `B_load`, `AluOut_load`, `EPC_load` out 1: register loads.
- `wr` out 1: memory write (1) or read (0).
- `RegWrite` out 1: register bank write.
- `IorD` out 1: memory address select, 0 = PC, 1 = AluOut.
- `RegDst` out 1: write register, 0 = rt, 1 = rd.
- `MemtoReg` out 1: write data, 0 = AluOut, 1 = MDR.
- `ALUSrcA` out 1: 0 = PC, 1 = A.
- `ALUSrcB` out 2: 00 = B, 01 = 4, 10 = sext(imm), 11 = sext(imm)<<2.
- `ALU_sel` out 3: ula32 code; 001 = add, 010 = sub, 011 = and, 110 = xor, 111 = compare.
- `PCSource` out 2: 00 = ALU, 01 = AluOut, 10 = {PC[31:28], instr[25:0], 2'b00}, 11 = exception vector.
- `Estado` out 8: current state code.

## Operation
- States and codes: RESET 0, FETCH 1, FETCH_WAIT 2, DECODE 3, MEM_ADDR 4, LW_READ 5, LW_WAIT 6, LW_WB 7, SW_WRITE 8, R_EXEC 9, R_WB 10, BRANCH 11, JUMP 12, ADDI_EXEC 13, ADDI_WB 14, EXC_OVF 15, EXC_OPC 16.
- All strobes default to 0 and all selects default to 0 in every state unless listed below.
- RESET: assert all three resets. Next state is FETCH.
- FETCH: IorD = 0, wr = 0.
- FETCH_WAIT: IRWrite = 1. PC ← PC + 4 (ALUSrcA = 0, ALUSrcB = 01, add, PCSource = 00, PC_load = 1).
- DECODE: A_load = 1, B_load = 1. AluOut ← PC + (sext<<2) (ALUSrcB = 11, add, AluOut_load = 1).
- Dispatch from DECODE:
  - op 0x00 with funct 0x20/0x22/0x24/0x26/0x2A → R_EXEC.
  - 0x23 or 0x2B → MEM_ADDR.
  - 0x04 or 0x05 → BRANCH.
  - 0x02 → JUMP.
  - 0x08 → ADDI_EXEC.
  - Anything else → EXC_OPC.
- R_EXEC: ALUSrcA = 1, ALUSrcB = 00, ALU_sel from funct (add/sub/and/xor/compare), AluOut_load = 1.
  - Overflow with funct 0x20 or 0x22 → EXC_OVF; otherwise → R_WB.
- R_WB: RegDst = 1, MemtoReg = 0, RegWrite = 1 → FETCH.
- ADDI_EXEC: A + sext, AluOut_load = 1. Overflow → EXC_OVF; otherwise → ADDI_WB.
- ADDI_WB: RegDst = 0, RegWrite = 1 → FETCH.
- MEM_ADDR: A + sext, AluOut_load = 1. lw → LW_READ; sw → SW_WRITE.
- LW_READ: IorD = 1 → LW_WAIT.
- LW_WAIT: MDR_load = 1 → LW_WB.
- LW_WB: MemtoReg = 1, RegDst = 0, RegWrite = 1 → FETCH.
- SW_WRITE: IorD = 1, wr = 1 → FETCH.
- BRANCH: A − B (ALUSrcA = 1, ALUSrcB = 00, sub), PCSource = 01.
  - PC_load = Zero for beq, PC_load = ~Zero for bne. This is the only Mealy output.
  - Next state is FETCH.
- JUMP: PCSource = 10, PC_load = 1 → FETCH.
- EXC_OVF / EXC_OPC: EPC ← PC − 4 (ALUSrcA = 0, ALUSrcB = 01, sub, EPC_load = 1). Also PCSource = 11, PC_load = 1. Next state is FETCH.
- Register writes from an overflowing instruction never occur: R_WB/ADDI_WB are skipped.

## Timing
- While Reset_n = 0:
  - State is forced to RESET, Estado = 0.
  - PC_reset, MDR_reset and Instr_Reg_reset = 1.
  - Every other output = 0.
- RESET persists for one rising edge after Reset_n deasserts.
- Reset asserted mid-instruction aborts immediately and asynchronously. No write strobe may remain high.
- Memory read latency is one cycle; data is valid in the state after the address is presented.
- Instruction latencies including fetch, in cycles: R-type 5, addi 5, lw 7, sw 5, beq/bne 4, j 4, exception 4.
- Estado changes only on a rising Clk edge, except on reset.
- Overflow and Zero are sampled only in R_EXEC, ADDI_EXEC and BRANCH; elsewhere they are ignored.

## Configuration
- `MIPS_EXCEPTION_EN` defined: EXC_OVF and EXC_OPC exist as specified.
- `MIPS_EXCEPTION_EN` undefined:
  - Overflow is ignored and the write-back proceeds.
  - Unknown opcode/funct returns DECODE → FETCH as a NOP.
  - EPC_load is tied to 0 and PCSource never equals 11.
  - State codes 15 and 16 are unreachable.

## Test plan
- Reset_n low for 3 cycles then high:
  - Estado = 0 while low, with PC_reset = 1 and all writes 0.
  - Estado sequence after release: 0, 1, 2, 3.
- add $3,$1,$2 (0x00221820), no overflow:
  - Estado 1, 2, 3, 9, 10, 1.
  - In state 10: RegWrite = 1, RegDst = 1.
- lw $4,8($1) (0x8C240008): Estado 1, 2, 3, 4, 5, 6, 7; IorD = 1 in state 5; MDR_load = 1 in state 6; MemtoReg = 1 in state 7.
- beq with Zero = 1 gives PC_load = 1, PCSource = 01 in state 11. The same instruction with Zero = 0 gives PC_load = 0. bne gives the inverse.
- With MIPS_EXCEPTION_EN:
  - addi with Overflow = 1 in state 13 → state 15, EPC_load = 1, PCSource = 11, no RegWrite.
  - Opcode 0x3F → state 16.
- Without MIPS_EXCEPTION_EN: opcode 0x3F gives Estado 3 → 1. Overflow add still reaches state 10 with RegWrite = 1.
